// File: rtl/pi_servo.sv
// Proportional-integral servo stage fed by the IIR error filter.
// Power-of-two gains, one sample at a time, clamped actuator output with anti-windup.
module pi_servo #(
  parameter int DATAWIDTH  = 16,
  parameter int SHIFTWIDTH = 4,
  parameter int FRACBITS   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         din_valid,
  input  logic signed [DATAWIDTH-1:0]  din,
  input  logic signed [DATAWIDTH-1:0]  setpoint,
  input  logic        [SHIFTWIDTH-1:0] kp_shift,
  input  logic        [SHIFTWIDTH-1:0] ki_shift,
  input  logic                         hold,
  input  logic                         clear,
  input  logic signed [DATAWIDTH-1:0]  out_min,
  input  logic signed [DATAWIDTH-1:0]  out_max,
  output logic signed [DATAWIDTH-1:0]  dout,
  output logic                         dout_valid,
  output logic                         railed_hi,
  output logic                         railed_lo,
  output logic                         overrun
);

  localparam int ACCW = DATAWIDTH + FRACBITS + 2;
  localparam int EW   = DATAWIDTH + 1;

  localparam logic signed [ACCW-1:0]      ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0]      ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [DATAWIDTH-1:0] DW_MAX  = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [DATAWIDTH-1:0] DW_MIN  = {1'b1, {(DATAWIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_PTERM = 3'd2,
    S_ACC   = 3'd3,
    S_SUM   = 3'd4
  } state_t;

  // Saturating ACCW-bit add: overflow is detected on the extra carry bit.
  function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                      input logic signed [ACCW-1:0] b);
    logic signed [ACCW:0] s;
    s = {a[ACCW-1], a} + {b[ACCW-1], b};
    if (s[ACCW] != s[ACCW-1]) begin
      sat_add = s[ACCW] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_add = s[ACCW-1:0];
    end
  endfunction

  // Saturate a wide signed value into the DATAWIDTH signed range.
  function automatic logic signed [DATAWIDTH-1:0] sat_dw(input logic signed [ACCW:0] v);
    if ((&v[ACCW:DATAWIDTH-1]) || (~|v[ACCW:DATAWIDTH-1])) begin
      sat_dw = v[DATAWIDTH-1:0];
    end else begin
      sat_dw = v[ACCW] ? DW_MIN : DW_MAX;
    end
  endfunction

  state_t                      state_r;
  logic signed [EW-1:0]        e_r;
  logic signed [ACCW-1:0]      ex_r;
  logic signed [ACCW-1:0]      p_r;
  logic signed [ACCW-1:0]      acc_r;

  logic                        e_pos_s;
  logic                        e_neg_s;
  logic                        blocked_s;
  logic signed [ACCW-1:0]      acc_next_s;
  logic signed [ACCW:0]        sum_s;
  logic signed [ACCW:0]        u_s;
  logic signed [DATAWIDTH-1:0] usat_s;
  logic signed [DATAWIDTH-1:0] mid_s;
  logic signed [DATAWIDTH-1:0] final_s;
  logic                        hi_s;
  logic                        lo_s;

  // Integrator update: clear on zero gain, freeze on hold or when pushing further into a rail.
  always_comb begin
    e_pos_s    = (!ex_r[ACCW-1]) && (ex_r != {ACCW{1'b0}});
    e_neg_s    = ex_r[ACCW-1];
    blocked_s  = (railed_hi && e_pos_s) || (railed_lo && e_neg_s);
    acc_next_s = acc_r;
    if (ki_shift == {SHIFTWIDTH{1'b0}}) begin
      acc_next_s = {ACCW{1'b0}};
    end else if (!hold && !blocked_s) begin
      acc_next_s = sat_add(acc_r, ex_r <<< ki_shift);
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Output path: floor-shift, saturate, then clamp high followed by low so out_min wins.
  always_comb begin
    sum_s   = {p_r[ACCW-1], p_r} + {acc_r[ACCW-1], acc_r};
    u_s     = sum_s >>> FRACBITS;
    usat_s  = sat_dw(u_s);
    hi_s    = (usat_s > out_max);
    mid_s   = hi_s ? out_max : usat_s;
    lo_s    = (mid_s < out_min);
    final_s = lo_s ? out_min : mid_s;
  end

  // Sequencer and all registered state; clear aborts the sample and empties the integrator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      e_r        <= {EW{1'b0}};
      ex_r       <= {ACCW{1'b0}};
      p_r        <= {ACCW{1'b0}};
      acc_r      <= {ACCW{1'b0}};
      dout       <= {DATAWIDTH{1'b0}};
      dout_valid <= 1'b0;
      railed_hi  <= 1'b0;
      railed_lo  <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state_r    <= S_IDLE;
      acc_r      <= {ACCW{1'b0}};
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid && (state_r != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (din_valid) begin
            e_r     <= {setpoint[DATAWIDTH-1], setpoint} - {din[DATAWIDTH-1], din};
            state_r <= S_ERR;
          end
        end
        S_ERR: begin
          ex_r    <= {{(ACCW-EW){e_r[EW-1]}}, e_r};
          state_r <= S_PTERM;
        end
        S_PTERM: begin
          p_r     <= (kp_shift == {SHIFTWIDTH{1'b0}}) ? {ACCW{1'b0}} : (ex_r <<< kp_shift);
          state_r <= S_ACC;
        end
        S_ACC: begin
          acc_r   <= acc_next_s;
          state_r <= S_SUM;
        end
        S_SUM: begin
          dout       <= final_s;
          railed_hi  <= hi_s && !lo_s;
          railed_lo  <= lo_s;
          dout_valid <= 1'b1;
          state_r    <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_servo.sv
// Directed bench for pi_servo: reference model pushes expected outputs to a scoreboard,
// a negedge monitor pops and compares them whenever dout_valid fires.
module tb_pi_servo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               din_valid = 1'b0;
  logic signed [15:0] din = 16'sd0;
  logic signed [15:0] setpoint = 16'sd0;
  logic        [4:0]  kp_shift = 5'd0;
  logic        [4:0]  ki_shift = 5'd0;
  logic               hold = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] out_min = -16'sd32767;
  logic signed [15:0] out_max = 16'sd32767;
  logic signed [15:0] dout;
  logic               dout_valid, railed_hi, railed_lo, overrun;

  pi_servo #(.DATAWIDTH(16), .SHIFTWIDTH(5), .FRACBITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .setpoint(setpoint),
    .kp_shift(kp_shift), .ki_shift(ki_shift), .hold(hold), .clear(clear),
    .out_min(out_min), .out_max(out_max), .dout(dout), .dout_valid(dout_valid),
    .railed_hi(railed_hi), .railed_lo(railed_lo), .overrun(overrun)
  );

  typedef struct {
    logic signed [15:0] d;
    logic               hi;
    logic               lo;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     n_pulse = 0;
  longint m_acc = 0;
  logic   m_hi = 1'b0;
  logic   m_lo = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference model of one complete sample with the current gain/clamp settings.
  task automatic predict(input int e);
    longint p, u, inc;
    logic   blk;
    exp_t   x;
    p = (kp_shift == 5'd0) ? 64'sd0 : (longint'(e) <<< kp_shift);
    if (ki_shift == 5'd0) begin
      m_acc = 0;
    end else begin
      blk = (m_hi && (e > 0)) || (m_lo && (e < 0));
      if (!hold && !blk) begin
        inc   = longint'(e) <<< ki_shift;
        m_acc = m_acc + inc;
        if (m_acc > 64'sd8589934591) m_acc = 64'sd8589934591;
        if (m_acc < -64'sd8589934592) m_acc = -64'sd8589934592;
      end
    end
    u = (p + m_acc) >>> 16;
    if (u > 32767) u = 32767;
    if (u < -32768) u = -32768;
    x.hi = 1'b0;
    x.lo = 1'b0;
    if (u > longint'(out_max)) begin u = out_max; x.hi = 1'b1; end
    if (u < longint'(out_min)) begin u = out_min; x.lo = 1'b1; x.hi = 1'b0; end
    x.d  = 16'(u);
    m_hi = x.hi;
    m_lo = x.lo;
    sb.push_back(x);
  endtask

  // Scoreboard monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    exp_t x;
    if (dout_valid === 1'b1) begin
      n_pulse++;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: got dout_valid=1 dout=%0d required no output", dout);
      end
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("sb_dout", dout, x.d);
        chk("sb_railed_hi", railed_hi, x.hi);
        chk("sb_railed_lo", railed_lo, x.lo);
      end
    end
  end

  task automatic send(input int sp, input int d);
    int lat;
    @(negedge clk);
    setpoint  = 16'(sp);
    din       = 16'(d);
    din_valid = 1'b1;
    predict(sp - d);
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) din_valid = 1'b0;
      if ((dout_valid === 1'b1) && (lat == 0)) lat = i;
    end
    chk("latency", lat, 5);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_acc = 0;
  endtask

  initial begin
    int p0;
    logic signed [15:0] d0;

    // reset state
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_railed_hi", railed_hi, 0);
    chk("rst_railed_lo", railed_lo, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // P only
    kp_shift = 5'd16; ki_shift = 5'd0;
    send(0, -100);
    chk("p_only_pos", dout, 100);
    send(0, 100);
    chk("p_only_neg", dout, -100);

    // I only, then hold
    kp_shift = 5'd0; ki_shift = 5'd12;
    send(100, 0); chk("i_only_1", dout, 6);
    send(100, 0); chk("i_only_2", dout, 12);
    send(100, 0); chk("i_only_3", dout, 18);
    send(100, 0); chk("i_only_4", dout, 25);
    hold = 1'b1;
    send(100, 0); chk("i_hold", dout, 25);
    hold = 1'b0;

    // clamp and anti-windup
    pulse_clear();
    kp_shift = 5'd16; ki_shift = 5'd12; out_max = 16'sd1000;
    send(5000, 0);
    chk("clamp_dout", dout, 1000);
    chk("clamp_railed_hi", railed_hi, 1);
    send(5000, 0);
    chk("windup_dout", dout, 1000);
    send(0, 100);
    chk("unwind_dout", dout, 206);
    chk("unwind_railed_hi", railed_hi, 0);
    send(0, 100);
    chk("unwind2_dout", dout, 200);

    // overrun: back-to-back din_valid yields a single output
    chk("overrun_before", overrun, 0);
    p0 = n_pulse;
    @(negedge clk);
    setpoint = 16'sd0; din = 16'sd10; din_valid = 1'b1;
    predict(-10);
    @(negedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("overrun_pulses", n_pulse - p0, 1);
    chk("overrun_flag", overrun, 1);

    // clear during PTERM aborts the sample and empties the integrator
    p0 = n_pulse;
    d0 = dout;
    @(negedge clk);
    setpoint = 16'sd3000; din = 16'sd0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_acc = 0;
    repeat (8) @(negedge clk);
    chk("clear_no_pulse", n_pulse - p0, 0);
    chk("clear_dout_held", dout, d0);
    kp_shift = 5'd0; ki_shift = 5'd12; out_max = 16'sd32767;
    send(100, 0);
    chk("clear_acc_zero", dout, 6);

    // ki_shift=0 clears the integrator, then inverted clamps
    send(100, 0); chk("reacc", dout, 12);
    ki_shift = 5'd0;
    send(100, 0); chk("ki0_out", dout, 0);
    out_min = 16'sd50; out_max = -16'sd50;
    send(0, 0);
    chk("inv_clamp_dout", dout, 50);
    chk("inv_clamp_railed_lo", railed_lo, 1);
    chk("inv_clamp_railed_hi", railed_hi, 0);
    out_min = -16'sd32767; out_max = 16'sd32767;
    ki_shift = 5'd12;
    send(100, 0); chk("ki0_acc_cleared", dout, 6);

    // reset mid-sample (during ACC)
    @(negedge clk);
    setpoint = 16'sd1000; din = 16'sd0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 0);
    chk("midrst_dout_valid", dout_valid, 0);
    chk("midrst_railed_hi", railed_hi, 0);
    chk("midrst_railed_lo", railed_lo, 0);
    chk("midrst_overrun", overrun, 0);
    m_acc = 0; m_hi = 1'b0; m_lo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    kp_shift = 5'd16; ki_shift = 5'd0;
    send(0, 100);
    chk("post_rst", dout, -100);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
